// File: rtl/t_ff_seq_ctrl_if.sv
// Command and bank bundle between a requester/T-FF bank (master) and the sequencer (slave).
// Widths follow the bank width N and the step-count width C.
interface t_ff_seq_ctrl_if #(
    parameter int N = 8,
    parameter int C = 8
);
    logic         start;
    logic [1:0]   mode;
    logic [N-1:0] value;
    logic [C-1:0] steps;
    logic         abort;
    logic [N-1:0] Q;
    logic [N-1:0] T;
    logic         busy;
    logic         done;

    modport master (
        output start, mode, value, steps, abort, Q,
        input  T, busy, done
    );

    modport slave (
        input  start, mode, value, steps, abort, Q,
        output T, busy, done
    );
endinterface

// File: rtl/t_ff_seq_ctrl.sv
// Sequencer for an N-bit bank of toggle flip-flops: loads, counts up or counts down
// using only T inputs, under a start/busy/done handshake with abort.
module t_ff_seq_ctrl #(
    parameter int N = 8,
    parameter int C = 8
) (
    input  logic            CLK,
    input  logic            INIT,
    t_ff_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [1:0]   M_LOAD  = 2'b00;
    localparam logic [1:0]   M_UP    = 2'b01;
    localparam logic [1:0]   M_DOWN  = 2'b10;
    localparam logic [C-1:0] CNT_ONE = C'(1);

    state_t       r_state;
    logic [1:0]   r_mode;
    logic [N-1:0] r_value;
    logic [C-1:0] r_cnt;
    logic         r_busy;
    logic         r_done;
    logic [N-1:0] w_T;

    // Bit i toggles on increment when every lower bit is one.
    function automatic logic [N-1:0] f_up_toggles(input logic [N-1:0] q);
        logic [N-1:0] t;
        logic         acc;
        acc = 1'b1;
        for (int i = 0; i < N; i++) begin
            t[i] = acc;
            acc  = acc & q[i];
        end
        return t;
    endfunction

    // Bit i toggles on decrement when every lower bit is zero.
    function automatic logic [N-1:0] f_down_toggles(input logic [N-1:0] q);
        logic [N-1:0] t;
        logic         acc;
        acc = 1'b1;
        for (int i = 0; i < N; i++) begin
            t[i] = acc;
            acc  = acc & ~q[i];
        end
        return t;
    endfunction

    // Abort blanks T immediately so the aborting edge applies no further toggle.
    always_comb begin
        w_T = '0;
        if (!bus.abort) begin
            case (r_state)
                S_LOAD: w_T = bus.Q ^ r_value;
                S_RUN: begin
                    case (r_mode)
                        M_UP:    w_T = f_up_toggles(bus.Q);
                        M_DOWN:  w_T = f_down_toggles(bus.Q);
                        default: w_T = '0;
                    endcase
                end
                default: w_T = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge INIT) begin
        if (!INIT) begin
            r_state <= S_IDLE;
            r_mode  <= '0;
            r_value <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        r_mode  <= bus.mode;
                        r_value <= bus.value;
                        r_cnt   <= bus.steps;
                        if (bus.mode == M_LOAD) begin
                            r_state <= S_LOAD;
                            r_busy  <= 1'b1;
                        end else if (bus.steps == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_busy <= 1'b0;
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_ONE) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.T    = w_T;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_t_ff_seq_ctrl.sv
// Bench for t_ff_seq_ctrl: a behavioural T-FF bank closes the loop; a scoreboard
// holds the expected bank value and cycle of every done pulse.
module tb_t_ff_seq_ctrl;
    localparam int N = 8;
    localparam int C = 8;
    localparam logic [N-1:0] UP_Q [3] = '{8'hFF, 8'h00, 8'h01};

    typedef struct {
        int           when;
        logic [N-1:0] q;
        string        tag;
    } exp_t;

    logic CLK  = 1'b0;
    logic INIT = 1'b0;
    int   cyc  = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];
    exp_t m_e;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    t_ff_seq_ctrl_if #(.N(N), .C(C)) u_if ();

    t_ff_seq_ctrl #(.N(N), .C(C)) dut (
        .CLK  (CLK),
        .INIT (INIT),
        .bus  (u_if)
    );

    // T flip-flop bank sharing clock and reset with the sequencer.
    always @(posedge CLK or negedge INIT) begin
        if (!INIT) u_if.Q <= '0;
        else       u_if.Q <= u_if.Q ^ u_if.T;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (INIT && u_if.done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: actual done=1 at cycle %0d required done=0", cyc);
            end else begin
                m_e = sb.pop_front();
                chk({m_e.tag, "_done_q"},    u_if.Q,    m_e.q);
                chk({m_e.tag, "_done_cyc"},  cyc,       m_e.when);
                chk({m_e.tag, "_done_busy"}, u_if.busy, 32'd0);
                chk({m_e.tag, "_done_T"},    u_if.T,    32'd0);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [1:0] m, input logic [N-1:0] v, input logic [C-1:0] s,
                         input bit push, input logic [N-1:0] eq, input int lat, input string tag);
        u_if.start = 1'b1;
        u_if.mode  = m;
        u_if.value = v;
        u_if.steps = s;
        step();
        if (push) sb.push_back('{cyc + lat, eq, tag});
        u_if.start = 1'b0;
        u_if.mode  = ~m;
        u_if.value = ~v;
        u_if.steps = s + 8'd7;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (!u_if.busy && !u_if.done) ok = 1'b1;
            else step();
        end
        chk({tag, "_idle_reached"}, ok, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual no finish required finish by 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        u_if.start = 1'b0;
        u_if.abort = 1'b0;
        u_if.mode  = 2'b00;
        u_if.value = '0;
        u_if.steps = '0;
        INIT       = 1'b0;

        // 1 reset
        step();
        step();
        chk("rst_T",    u_if.T,    32'd0);
        chk("rst_busy", u_if.busy, 32'd0);
        chk("rst_done", u_if.done, 32'd0);
        chk("rst_Q",    u_if.Q,    32'd0);
        @(negedge CLK);
        INIT = 1'b1;
        step();
        chk("rel_T",    u_if.T,    32'd0);
        chk("rel_busy", u_if.busy, 32'd0);
        chk("rel_Q",    u_if.Q,    32'd0);

        // 2 load A5 (inputs scrambled after the start edge)
        issue(2'b00, 8'hA5, 8'd0, 1'b1, 8'hA5, 1, "load_a5");
        chk("load_a5_busy", u_if.busy, 32'd1);
        chk("load_a5_T",    u_if.T,    32'hA5);
        step();
        chk("load_a5_q",    u_if.Q,    32'hA5);
        chk("load_a5_done", u_if.done, 32'd1);
        wait_idle("load_a5");

        // 3 load FE then count up 3 with wrap; start while busy is ignored
        issue(2'b00, 8'hFE, 8'd0, 1'b1, 8'hFE, 1, "load_fe");
        step();
        wait_idle("load_fe");
        issue(2'b01, 8'h00, 8'd3, 1'b1, 8'h01, 3, "up3");
        u_if.start = 1'b1;
        u_if.mode  = 2'b00;
        u_if.value = 8'h55;
        chk("up3_busy0", u_if.busy, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("up3_q%0d", i), u_if.Q, UP_Q[i]);
            chk($sformatf("up3_busy%0d", i + 1), u_if.busy, (i < 2) ? 32'd1 : 32'd0);
        end
        u_if.start = 1'b0;
        wait_idle("up3");

        // 4 down 2 with wrap, then steps==0
        issue(2'b10, 8'h00, 8'd2, 1'b1, 8'hFF, 2, "down2");
        step();
        chk("down2_q0", u_if.Q, 32'h00);
        step();
        chk("down2_q1", u_if.Q, 32'hFF);
        wait_idle("down2");
        issue(2'b10, 8'h00, 8'd0, 1'b1, 8'hFF, 0, "down0");
        chk("down0_busy", u_if.busy, 32'd0);
        chk("down0_done", u_if.done, 32'd1);
        u_if.start = 1'b1;
        u_if.mode  = 2'b00;
        u_if.value = 8'h55;
        u_if.abort = 1'b1;
        step();
        u_if.start = 1'b0;
        u_if.abort = 1'b0;
        chk("done_start_busy", u_if.busy, 32'd0);
        chk("done_start_q",    u_if.Q,    32'hFF);
        step();
        chk("done_start_q2",   u_if.Q,    32'hFF);

        // 5 abort after four toggle edges; start with abort rejected
        issue(2'b00, 8'h10, 8'd0, 1'b1, 8'h10, 1, "load_10");
        step();
        wait_idle("load_10");
        issue(2'b01, 8'h00, 8'd10, 1'b0, 8'h00, 0, "up10");
        repeat (4) step();
        chk("abort_pre_q",    u_if.Q,    32'h14);
        chk("abort_pre_busy", u_if.busy, 32'd1);
        u_if.abort = 1'b1;
        u_if.start = 1'b1;
        u_if.mode  = 2'b00;
        u_if.value = 8'h77;
        #1;
        chk("abort_T", u_if.T, 32'd0);
        step();
        chk("abort_busy", u_if.busy, 32'd0);
        chk("abort_q",    u_if.Q,    32'h14);
        step();
        chk("abort_start_busy", u_if.busy, 32'd0);
        chk("abort_start_q",    u_if.Q,    32'h14);
        u_if.abort = 1'b0;
        u_if.start = 1'b0;
        step();
        step();
        chk("abort_q_hold", u_if.Q, 32'h14);

        // 6 reset mid-run, then a fresh load
        issue(2'b01, 8'h00, 8'd20, 1'b0, 8'h00, 0, "up20");
        repeat (3) step();
        chk("midrst_pre_q", u_if.Q, 32'h17);
        INIT = 1'b0;
        #1;
        chk("midrst_busy", u_if.busy, 32'd0);
        chk("midrst_T",    u_if.T,    32'd0);
        chk("midrst_done", u_if.done, 32'd0);
        chk("midrst_Q",    u_if.Q,    32'd0);
        step();
        @(negedge CLK);
        INIT = 1'b1;
        step();
        issue(2'b00, 8'h3C, 8'd0, 1'b1, 8'h3C, 1, "load_3c");
        chk("load_3c_T", u_if.T, 32'h3C);
        step();
        wait_idle("load_3c");
        step();
        chk("load_3c_q", u_if.Q, 32'h3C);

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
